// File: rtl/r4_qds_constants_pipe_if.sv
// Bundle of handshake, index and constant signals for r4_qds_constants_pipe.
// The slave modport is the generator's view, the master modport is the
// requester/consumer view. CW must equal 7+INT_EXT+FRAC_EXT of the generator.
// Optional parity bus present when R4_QDS_CONST_PARITY_EN is defined.
interface r4_qds_constants_pipe_if #(
    parameter int LANES = 1,
    parameter int CW    = 7
);
    logic                  flush_i;
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [LANES*4-1:0]    idx_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [LANES*CW-1:0]   m_neg_1_o;
    logic [LANES*CW-1:0]   m_neg_0_o;
    logic [LANES*CW-1:0]   m_pos_1_o;
    logic [LANES*CW-1:0]   m_pos_2_o;
    logic [LANES-1:0]      changed_o;
`ifdef R4_QDS_CONST_PARITY_EN
    logic [LANES*4-1:0]    par_o;
`endif

    modport slave (
        input  flush_i,
        input  in_valid_i,
        output in_ready_o,
        input  idx_i,
        output out_valid_o,
        input  out_ready_i,
        output m_neg_1_o,
        output m_neg_0_o,
        output m_pos_1_o,
        output m_pos_2_o,
`ifdef R4_QDS_CONST_PARITY_EN
        output par_o,
`endif
        output changed_o
    );

    modport master (
        output flush_i,
        output in_valid_i,
        input  in_ready_o,
        output idx_i,
        input  out_valid_o,
        output out_ready_i,
        input  m_neg_1_o,
        input  m_neg_0_o,
        input  m_pos_1_o,
        input  m_pos_2_o,
`ifdef R4_QDS_CONST_PARITY_EN
        input  par_o,
`endif
        input  changed_o
    );
endinterface

// File: rtl/r4_qds_constants_pipe.sv
// Multi-lane registered radix-4 sqrt QDS selection-constant generator.
// Each lane maps its root-prefix index {a0,a2,a3,a4} to -m[-1], -m[-0],
// -m[+1], -m[+2] (two's complement, 3 fraction bits), widened by INT_EXT
// sign bits on top and FRAC_EXT zero bits below.
// Optional feature macro: R4_QDS_CONST_PARITY_EN adds per-constant even parity.
//
// Handshake: a capture happens on a rising clk edge when in_valid_i and
// in_ready_o are both high and flush_i is low; in_ready_o = ~out_valid_o |
// out_ready_i, so while out_valid_o is high and out_ready_i low every output
// is held stable and no new index is taken. flush_i wins over everything.
module r4_qds_constants_pipe #(
    parameter int LANES    = 1,
    parameter int INT_EXT  = 0,
    parameter int FRAC_EXT = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    r4_qds_constants_pipe_if.slave bus
);
    localparam int CW = 7 + INT_EXT + FRAC_EXT;

    // Base table rows i = {a2,a3,a4}; 7-bit values in units of 1/8.
    localparam logic [6:0] T_NEG1 [8] = '{7'd13, 7'd14, 7'd16, 7'd17,
                                          7'd18, 7'd20, 7'd22, 7'd23};
    localparam logic [6:0] T_NEG0 [8] = '{7'd4, 7'd5, 7'd6, 7'd6,
                                          7'd6, 7'd8, 7'd8, 7'd8};
    localparam logic [6:0] T_POS1 [8] = '{-7'sd4, -7'sd4, -7'sd4, -7'sd4,
                                          -7'sd6, -7'sd6, -7'sd8, -7'sd8};
    localparam logic [6:0] T_POS2 [8] = '{-7'sd12, -7'sd14, -7'sd16, -7'sd16,
                                          -7'sd18, -7'sd20, -7'sd20, -7'sd22};

    // Sign-extend to CW bits, then shift left to open FRAC_EXT zero bits.
    function automatic logic [CW-1:0] widen(input logic [6:0] b);
        logic signed [CW-1:0] s;
        s = CW'($signed(b));
        return s <<< FRAC_EXT;
    endfunction

    // Row-0 values so downstream always sees legal constants after reset.
    localparam logic [CW-1:0] ROW0_N1 = widen(T_NEG1[0]);
    localparam logic [CW-1:0] ROW0_N0 = widen(T_NEG0[0]);
    localparam logic [CW-1:0] ROW0_P1 = widen(T_POS1[0]);
    localparam logic [CW-1:0] ROW0_P2 = widen(T_POS2[0]);

    logic                  r_valid;
    logic [LANES*CW-1:0]   r_n1, r_n0, r_p1, r_p2;
    logic [LANES-1:0]      r_changed;
    // History holds the normalised row (a0=1 folds to row 7), so 3 bits suffice.
    logic [LANES*3-1:0]    r_hist;

    logic [LANES*CW-1:0]   w_nxt_n1, w_nxt_n0, w_nxt_p1, w_nxt_p2;
    logic [LANES-1:0]      w_chg;
    logic [LANES*3-1:0]    w_hist_nxt;
    logic                  w_in_ready;
    logic                  w_capture;

`ifdef R4_QDS_CONST_PARITY_EN
    localparam logic [3:0] PAR0 = {^ROW0_P2, ^ROW0_P1, ^ROW0_N0, ^ROW0_N1};
    logic [LANES*4-1:0]    r_par;
    logic [LANES*4-1:0]    w_nxt_par;
`endif

    assign w_in_ready = ~r_valid | bus.out_ready_i;
    assign w_capture  = bus.in_valid_i & w_in_ready & ~bus.flush_i;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [2:0] w_row;
        assign w_row = bus.idx_i[4*k+3] ? 3'd7 : bus.idx_i[4*k +: 3];
        assign w_nxt_n1[k*CW +: CW] = widen(T_NEG1[w_row]);
        assign w_nxt_n0[k*CW +: CW] = widen(T_NEG0[w_row]);
        assign w_nxt_p1[k*CW +: CW] = widen(T_POS1[w_row]);
        assign w_nxt_p2[k*CW +: CW] = widen(T_POS2[w_row]);
        assign w_hist_nxt[k*3 +: 3] = w_row;
        assign w_chg[k]             = (w_row != r_hist[k*3 +: 3]);
`ifdef R4_QDS_CONST_PARITY_EN
        assign w_nxt_par[4*k+0] = ^w_nxt_n1[k*CW +: CW];
        assign w_nxt_par[4*k+1] = ^w_nxt_n0[k*CW +: CW];
        assign w_nxt_par[4*k+2] = ^w_nxt_p1[k*CW +: CW];
        assign w_nxt_par[4*k+3] = ^w_nxt_p2[k*CW +: CW];
`endif
    end

    // Output register: flush > capture > drain; constants only move on capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_changed <= '0;
            r_hist    <= '0;
            r_n1      <= {LANES{ROW0_N1}};
            r_n0      <= {LANES{ROW0_N0}};
            r_p1      <= {LANES{ROW0_P1}};
            r_p2      <= {LANES{ROW0_P2}};
`ifdef R4_QDS_CONST_PARITY_EN
            r_par     <= {LANES{PAR0}};
`endif
        end else if (bus.flush_i) begin
            r_valid   <= 1'b0;
            r_changed <= '0;
            r_hist    <= '0;
        end else if (w_capture) begin
            r_valid   <= 1'b1;
            r_changed <= w_chg;
            r_hist    <= w_hist_nxt;
            r_n1      <= w_nxt_n1;
            r_n0      <= w_nxt_n0;
            r_p1      <= w_nxt_p1;
            r_p2      <= w_nxt_p2;
`ifdef R4_QDS_CONST_PARITY_EN
            r_par     <= w_nxt_par;
`endif
        end else if (bus.out_ready_i) begin
            r_valid   <= 1'b0;
            r_changed <= '0;
        end
    end

    assign bus.in_ready_o  = w_in_ready;
    assign bus.out_valid_o = r_valid;
    assign bus.m_neg_1_o   = r_n1;
    assign bus.m_neg_0_o   = r_n0;
    assign bus.m_pos_1_o   = r_p1;
    assign bus.m_pos_2_o   = r_p2;
    assign bus.changed_o   = r_changed;
`ifdef R4_QDS_CONST_PARITY_EN
    assign bus.par_o       = r_par;
`endif
endmodule

// File: tb/tb_r4_qds_constants_pipe.sv
// Bench for r4_qds_constants_pipe: DUT A (LANES=1 defaults) and DUT B
// (LANES=2, INT_EXT=2, FRAC_EXT=1) checked every cycle against a table model,
// plus directed literal checks. Honours R4_QDS_CONST_PARITY_EN when defined.
module tb_r4_qds_constants_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    r4_qds_constants_pipe_if #(.LANES(1), .CW(7))  bus_a ();
    r4_qds_constants_pipe_if #(.LANES(2), .CW(10)) bus_b ();

    r4_qds_constants_pipe #(.LANES(1), .INT_EXT(0), .FRAC_EXT(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
    r4_qds_constants_pipe #(.LANES(2), .INT_EXT(2), .FRAC_EXT(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Selection constants in units of 1/8: [j][row], j 0=-m[-1] .. 3=-m[+2].
    int t_tab [4][8] = '{'{13, 14, 16, 17, 18, 20, 22, 23},
                         '{4, 5, 6, 6, 6, 8, 8, 8},
                         '{-4, -4, -4, -4, -6, -6, -8, -8},
                         '{-12, -14, -16, -16, -18, -20, -20, -22}};
    int d_lanes [2] = '{1, 2};
    int d_frac  [2] = '{0, 1};
    int d_cw    [2] = '{7, 10};
    string cname [4] = '{"m_neg_1", "m_neg_0", "m_pos_1", "m_pos_2"};

    // Model state per DUT.
    int m_valid [2];
    int m_const [2][2][4];
    int m_hist  [2][2];
    int m_chg   [2][2];

    // Sampled DUT outputs.
    int act_valid [2];
    int act_ready [2];
    int act_c     [2][2][4];
    int act_chg   [2][2];
    int act_par   [2][2][4];

    function automatic int row_of(input int idx);
        return (idx >= 8) ? 7 : idx;
    endfunction

    function automatic int exp_val(input int d, input int j, input int row);
        return t_tab[j][row] * (1 << d_frac[d]);
    endfunction

    function automatic int par_of(input int d, input int v);
        return $countones(v & ((1 << d_cw[d]) - 1)) % 2;
    endfunction

    task automatic chk(input string name, input int d, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s dut%0d @%0t: got %0d expected %0d", name, d, $time, got, exp);
        end
    endtask

    task automatic m_reset();
        for (int d = 0; d < 2; d++) begin
            m_valid[d] = 0;
            for (int k = 0; k < 2; k++) begin
                m_hist[d][k] = 0;
                m_chg[d][k]  = 0;
                for (int j = 0; j < 4; j++) m_const[d][k][j] = exp_val(d, j, 0);
            end
        end
    endtask

    task automatic m_step(input int d, input bit flush, input bit valid,
                          input bit ready, input int idx0, input int idx1);
        bit rdy;
        int r;
        rdy = (m_valid[d] == 0) || ready;
        if (flush) begin
            m_valid[d] = 0;
            for (int k = 0; k < 2; k++) begin
                m_chg[d][k]  = 0;
                m_hist[d][k] = 0;
            end
        end else if (valid && rdy) begin
            m_valid[d] = 1;
            for (int k = 0; k < d_lanes[d]; k++) begin
                r = row_of((k == 0) ? idx0 : idx1);
                m_chg[d][k]  = (r != m_hist[d][k]) ? 1 : 0;
                m_hist[d][k] = r;
                for (int j = 0; j < 4; j++) m_const[d][k][j] = exp_val(d, j, r);
            end
        end else if (ready) begin
            m_valid[d] = 0;
            for (int k = 0; k < 2; k++) m_chg[d][k] = 0;
        end
    endtask

    // Model advances on the same edges as the DUT registers.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_reset();
        end else begin
            m_step(0, bus_a.flush_i, bus_a.in_valid_i, bus_a.out_ready_i,
                   int'(bus_a.idx_i), 0);
            m_step(1, bus_b.flush_i, bus_b.in_valid_i, bus_b.out_ready_i,
                   int'(bus_b.idx_i[3:0]), int'(bus_b.idx_i[7:4]));
        end
    end

    task automatic cmp_dut(input int d, input bit out_ready);
        chk("out_valid", d, act_valid[d], m_valid[d]);
        chk("in_ready", d, act_ready[d], ((m_valid[d] == 0) || out_ready) ? 1 : 0);
        for (int k = 0; k < d_lanes[d]; k++) begin
            for (int j = 0; j < 4; j++) begin
                chk(cname[j], d, act_c[d][k][j], m_const[d][k][j]);
`ifdef R4_QDS_CONST_PARITY_EN
                chk("par", d, act_par[d][k][j], par_of(d, m_const[d][k][j]));
`endif
            end
            chk("changed", d, act_chg[d][k], m_chg[d][k]);
        end
    endtask

    // Compare process: sample on the falling edge, away from register updates.
    always @(negedge clk) begin
        if (chk_en) begin
            act_valid[0] = int'(bus_a.out_valid_o);
            act_ready[0] = int'(bus_a.in_ready_o);
            act_c[0][0][0] = $signed(bus_a.m_neg_1_o);
            act_c[0][0][1] = $signed(bus_a.m_neg_0_o);
            act_c[0][0][2] = $signed(bus_a.m_pos_1_o);
            act_c[0][0][3] = $signed(bus_a.m_pos_2_o);
            act_chg[0][0]  = int'(bus_a.changed_o);
            act_valid[1] = int'(bus_b.out_valid_o);
            act_ready[1] = int'(bus_b.in_ready_o);
            for (int k = 0; k < 2; k++) begin
                act_c[1][k][0] = $signed(bus_b.m_neg_1_o[k*10 +: 10]);
                act_c[1][k][1] = $signed(bus_b.m_neg_0_o[k*10 +: 10]);
                act_c[1][k][2] = $signed(bus_b.m_pos_1_o[k*10 +: 10]);
                act_c[1][k][3] = $signed(bus_b.m_pos_2_o[k*10 +: 10]);
                act_chg[1][k]  = int'(bus_b.changed_o[k]);
            end
`ifdef R4_QDS_CONST_PARITY_EN
            for (int j = 0; j < 4; j++) begin
                act_par[0][0][j] = int'(bus_a.par_o[j]);
                act_par[1][0][j] = int'(bus_b.par_o[j]);
                act_par[1][1][j] = int'(bus_b.par_o[4+j]);
            end
`endif
            cmp_dut(0, bus_a.out_ready_i);
            cmp_dut(1, bus_b.out_ready_i);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input bit flush, input bit valid, input bit ready, input int idx);
        bus_a.flush_i     = flush;
        bus_a.in_valid_i  = valid;
        bus_a.out_ready_i = ready;
        bus_a.idx_i       = 4'(idx);
    endtask

    task automatic drive_b(input bit flush, input bit valid, input bit ready, input int idx);
        bus_b.flush_i     = flush;
        bus_b.in_valid_i  = valid;
        bus_b.out_ready_i = ready;
        bus_b.idx_i       = 8'(idx);
    endtask

    task automatic chk_a_consts(input string name, input int n1, input int n0,
                                input int p1, input int p2);
        chk({name, "_m_neg_1"}, 0, $signed(bus_a.m_neg_1_o), n1);
        chk({name, "_m_neg_0"}, 0, $signed(bus_a.m_neg_0_o), n0);
        chk({name, "_m_pos_1"}, 0, $signed(bus_a.m_pos_1_o), p1);
        chk({name, "_m_pos_2"}, 0, $signed(bus_a.m_pos_2_o), p2);
    endtask

    initial begin
        drive_a(0, 0, 0, 0);
        drive_b(0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Reset state.
        chk("rst_out_valid", 0, bus_a.out_valid_o, 0);
        chk("rst_in_ready", 0, bus_a.in_ready_o, 1);
        chk("rst_changed", 0, bus_a.changed_o, 0);
        chk_a_consts("rst", 13, 4, -4, -12);

        // Sweep all 16 indices back to back; latency one cycle.
        for (int i = 0; i < 16; i++) begin
            drive_a(0, 1, 1, i);
            tick();
            chk("sweep_valid", 0, bus_a.out_valid_o, 1);
            if (i == 3) begin
                chk("sweep3_m_neg_1", 0, bus_a.m_neg_1_o, 7'b0010001);
                chk("sweep3_m_pos_2", 0, bus_a.m_pos_2_o, 7'b1110000);
            end
            if (i >= 8) chk_a_consts("sweep_a0", 23, 8, -8, -22);
        end
        drive_a(0, 0, 1, 0);
        tick();
        chk("drain_valid", 0, bus_a.out_valid_o, 0);
        chk_a_consts("drain_hold", 23, 8, -8, -22);

        // Backpressure: capture 5 then hold four cycles with a toggling index.
        drive_a(0, 1, 1, 5);
        tick();
        for (int c = 0; c < 4; c++) begin
            drive_a(0, 1, 0, $urandom_range(0, 15));
            tick();
            chk("bp_in_ready", 0, bus_a.in_ready_o, 0);
            chk("bp_valid", 0, bus_a.out_valid_o, 1);
            chk_a_consts("bp", 20, 8, -6, -20);
        end
        drive_a(0, 1, 1, 6);
        #1;
        chk("release_in_ready", 0, bus_a.in_ready_o, 1);
        tick();
        chk_a_consts("release", 22, 8, -8, -20);

        // Flush beats capture; constants stay, history clears.
        drive_a(1, 1, 0, 2);
        tick();
        chk("flush_valid", 0, bus_a.out_valid_o, 0);
        chk("flush_changed", 0, bus_a.changed_o, 0);
        chk_a_consts("flush", 22, 8, -8, -20);
        drive_a(0, 1, 1, 0);
        tick();
        chk("post_flush_changed", 0, bus_a.changed_o, 0);
        chk_a_consts("post_flush", 13, 4, -4, -12);
`ifdef R4_QDS_CONST_PARITY_EN
        chk("par_idx0", 0, bus_a.par_o,
            {par_of(0, -12) != 0, par_of(0, -4) != 0, par_of(0, 4) != 0, par_of(0, 13) != 0});
        chk("par_idx0_lit", 0, bus_a.par_o, 4'b0111);
`endif

        // Reset while holding idx 7.
        drive_a(0, 1, 1, 7);
        tick();
        chk("pre_rst_changed", 0, bus_a.changed_o, 1);
        drive_a(0, 0, 0, 7);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 0, bus_a.out_valid_o, 0);
        chk("midrst_changed", 0, bus_a.changed_o, 0);
        chk_a_consts("midrst", 13, 4, -4, -12);
        tick();
        rst_n = 1'b1;
        chk("post_rst_in_ready", 0, bus_a.in_ready_o, 1);

        // Wide two-lane configuration.
        drive_b(0, 1, 1, {4'd4, 4'd1});
        tick();
        chk("b_l0_m_pos_2", 1, bus_b.m_pos_2_o[9:0], 10'b1111100100);
        chk("b_l1_m_neg_1", 1, bus_b.m_neg_1_o[19:10], 10'b0000100100);
        chk("b_changed_first", 1, bus_b.changed_o, 2'b11);
        drive_b(0, 1, 1, {4'd4, 4'd9});
        tick();
        chk("b_changed_second", 1, bus_b.changed_o, 2'b01);
        chk("b_l0_a0_m_neg_1", 1, $signed(bus_b.m_neg_1_o[9:0]), 46);

        // Random traffic on both DUTs, with one reset in the middle.
        for (int c = 0; c < 1500; c++) begin
            drive_a($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 15));
            drive_b($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 255));
            if (c == 700) begin
                #2;
                rst_n = 1'b0;
            end
            if (c == 702) rst_n = 1'b1;
            tick();
        end
        drive_a(0, 0, 1, 0);
        drive_b(0, 0, 1, 0);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
